// File: rtl/cart_bus_arb.sv
// Cartridge bus arbiter: CPU and OAM-DMA requesters share one strobed external bus.
// Optional macro CART_DMA_ARB_EN enables the DMA requester; otherwise DMA is ignored.
module cart_bus_arb #(
  parameter int STRB_CYC = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        nrd,
  output logic        nwr,
  output logic        ncs
);

`ifdef CART_DMA_ARB_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, STRB, HOLD} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic       gnt_dma, we_q;
  logic       dma_go, any_req, strb_last, active;

  // DMA is masked at the source so the disabled build can never grant it
  assign dma_go    = DMA_EN & dma_req;
  assign any_req   = dma_go | cpu_req;
  assign strb_last = (cnt == 3'(STRB_CYC - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ADDR;
      ADDR:    state_nx = STRB;
      STRB:    if (strb_last) state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      gnt_dma   <= 1'b0;
      we_q      <= 1'b0;
      bus_a     <= '0;
      bus_dout  <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_dma  <= dma_go;
          we_q     <= ~dma_go & cpu_we;
          bus_a    <= dma_go ? dma_addr : cpu_addr;
          bus_dout <= cpu_wdata;
          cnt      <= '0;
        end
        STRB: begin
          cnt <= cnt + 3'd1;
          if (strb_last && !we_q) begin
            if (gnt_dma) dma_rdata <= bus_din;
            else         cpu_rdata <= bus_din;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus controls decode straight from state so reset releases them without a clock
  assign active  = (state != IDLE);
  assign nrd     = ~((state == STRB) & ~we_q);
  assign nwr     = ~((state == STRB) & we_q);
  assign bus_doe = active & we_q;
  assign ncs     = ~(active & (bus_a[15:13] == 3'b101));
  assign cpu_ack = (state == HOLD) & ~gnt_dma;
  assign dma_ack = (state == HOLD) & gnt_dma;

endmodule

// File: tb/tb_cart_bus_arb.sv
// Randomized bench for cart_bus_arb against a phase-based transaction model.
module tb_cart_bus_arb;
  localparam int S = 2;
`ifdef CART_DMA_ARB_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic        clk = 1'b0, nrst = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0]  cpu_wdata = '0, bus_din = '0;
  logic        cpu_ack, dma_ack, bus_doe, nrd, nwr, ncs;
  logic [7:0]  cpu_rdata, dma_rdata, bus_dout;
  logic [15:0] bus_a;

  cart_bus_arb #(.STRB_CYC(S)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .nrd(nrd), .nwr(nwr), .ncs(ncs)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: ph = -1 idle, 0 address phase, 1..S strobe phases, S+1 hold phase
  int          ph = -1;
  bit          m_dma, m_we;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wd = '0, m_crd = '0, m_drd = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ph = -1; m_addr = '0; m_wd = '0; m_crd = '0; m_drd = '0;
    end else if (ph < 0) begin
      if (DMA_EN && dma_req) begin
        m_dma = 1; m_we = 0; m_addr = dma_addr; m_wd = cpu_wdata; ph = 0;
      end else if (cpu_req) begin
        m_dma = 0; m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata; ph = 0;
      end
    end else if (ph <= S) begin
      if (ph == S && !m_we) begin
        if (m_dma) m_drd = bus_din;
        else       m_crd = bus_din;
      end
      ph++;
    end else begin
      ph = -1;
    end
  end

  task automatic check_outs();
    bit act, strb, hold;
    act  = (ph >= 0);
    strb = (ph >= 1 && ph <= S);
    hold = (ph == S + 1);
    chk("nrd", nrd, !(strb && !m_we));
    chk("nwr", nwr, !(strb && m_we));
    chk("bus_doe", bus_doe, act && m_we);
    chk("ncs", ncs, !(act && m_addr >= 16'hA000 && m_addr <= 16'hBFFF));
    chk("bus_a", bus_a, m_addr);
    if (act && m_we) chk("bus_dout", bus_dout, m_wd);
    chk("cpu_ack", cpu_ack, hold && !m_dma);
    chk("dma_ack", dma_ack, hold && m_dma);
    chk("cpu_rdata", cpu_rdata, m_crd);
    chk("dma_rdata", dma_rdata, m_drd);
    chk("ack_excl", cpu_ack & dma_ack, 0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    case ($urandom_range(3))
      0:       a = 16'hA000 | 16'($urandom_range(16'h1FFF));
      1:       a = 16'($urandom);
      2:       a = ($urandom_range(1) != 0) ? 16'h9FFF : 16'hC000;
      default: a = ($urandom_range(1) != 0) ? 16'hA000 : 16'hBFFF;
    endcase
    return a;
  endfunction

  // Called just after the negedge checks; request levels obey the hold-until-ack rule
  task automatic drive_in();
    if (ph == S + 1 && !m_dma)                                  cpu_req = 0;
    else if (!cpu_req && $urandom_range(2) == 0)                cpu_req = 1;
    else if (ph >= 1 && !m_dma && cpu_req && $urandom_range(9) == 0) cpu_req = 0;
    if (DMA_EN) begin
      if (ph == S + 1 && m_dma)                                 dma_req = 0;
      else if (!dma_req && $urandom_range(3) == 0)              dma_req = 1;
    end else begin
      dma_req = 1;
    end
    cpu_we    = 1'($urandom);
    cpu_addr  = rand_addr();
    cpu_wdata = 8'($urandom);
    dma_addr  = rand_addr();
    bus_din   = 8'($urandom);
  endtask

  initial begin
    bit found, got_ack;
    #3;
    chk("rst_nrd", nrd, 1);       chk("rst_nwr", nwr, 1);
    chk("rst_ncs", ncs, 1);       chk("rst_doe", bus_doe, 0);
    chk("rst_cpu_ack", cpu_ack, 0); chk("rst_dma_ack", dma_ack, 0);
    chk("rst_bus_a", bus_a, 0);   chk("rst_bus_dout", bus_dout, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_dma_rdata", dma_rdata, 0);
    @(negedge clk);
    nrst = 1;
    drive_in();

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      check_outs();
      drive_in();
    end

    // Abort a CPU write in its second strobe cycle, then expect a clean rerun
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      check_outs();
      if (ph == 2 && m_we && !m_dma) begin
        found     = 1;
        cpu_req   = 1;
        cpu_we    = 1;
        cpu_addr  = 16'hA010;
        cpu_wdata = 8'h3C;
        dma_req   = !DMA_EN;
        nrst      = 0;
        #1;
        chk("abort_nwr", nwr, 1);
        chk("abort_doe", bus_doe, 0);
        chk("abort_cpu_ack", cpu_ack, 0);
        chk("abort_bus_a", bus_a, 0);
        repeat (2) begin
          @(negedge clk);
          check_outs();
        end
        nrst = 1;
        got_ack = 0;
        for (int k = 0; k < S + 6 && !got_ack; k++) begin
          @(negedge clk);
          check_outs();
          if (cpu_ack) begin
            got_ack = 1;
            chk("rerun_dout", bus_dout, 8'h3C);
            cpu_req = 0;
          end
        end
        chk("rerun_ack", got_ack, 1);
      end else begin
        drive_in();
      end
    end
    chk("abort_found", found, 1);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check_outs();
      drive_in();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cart_bus_arb.md
CART_BUS_ARB -- requirements
Module: cart_bus_arb

Interface
REQ-001 The block SHALL have parameter STRB_CYC, default 2, number of clock cycles the read/write strobe is held low (legal range 1..7).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  captured read data, valid with cpu_ack.
- dma_req  in  1  OAM-DMA read request, held until dma_ack.
- dma_addr  in  16  DMA source address.
- dma_ack  out  1  one-cycle completion pulse.
- dma_rdata  out  8  captured read data, valid with dma_ack.
- bus_a  out  16  cartridge address bus.
- bus_dout  out  8  cartridge write data.
- bus_doe  out  1  write-data output enable.
- bus_din  in  8  cartridge read data.
- nrd, nwr  out  1 each  active-low read and write strobes.
- ncs  out  1  active-low external-RAM chip select.

Function
REQ-003 The block SHALL use FSM states IDLE, ADDR, STRB, HOLD.
REQ-004 IDLE: if any enabled request is high on an edge, the block SHALL latch grant, address, we and wdata, and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be fixed priority: dma_req wins over cpu_req when both are high in the same IDLE cycle.
REQ-006 A DMA grant SHALL always be a read, regardless of cpu_we.
REQ-007 ADDR SHALL last 1 cycle, with bus_a driven and nrd=nwr=1.
REQ-008 STRB SHALL last exactly STRB_CYC cycles, with nrd=0 for a read or nwr=0 for a write; the other strobe SHALL stay 1.
REQ-009 On the last STRB edge of a read, the block SHALL capture bus_din into the granted requester's rdata register.
REQ-010 HOLD SHALL last 1 cycle with strobes high and bus_a/bus_dout held; the granted ack SHALL be 1 in HOLD only, then the FSM returns to IDLE.
REQ-011 Latency SHALL be: request sampled in IDLE at edge N gives ack high during cycle N+2+STRB_CYC; back-to-back transactions SHALL be separated by one IDLE cycle.
REQ-012 bus_doe SHALL be 1 from ADDR through HOLD of a write transaction only; bus_dout SHALL equal the latched wdata.
REQ-013 ncs SHALL be 0 from ADDR through HOLD when the latched address is 0xA000..0xBFFF, and 1 otherwise.
REQ-014 In IDLE, bus_a SHALL hold its last value, with nrd=nwr=ncs=1 and bus_doe=0.
REQ-015 A request deasserted mid-transaction SHALL NOT abort it: the transaction completes and the ack still pulses.
REQ-016 Changes to address/data inputs after the grant SHALL have no effect until the next grant.
REQ-017 cpu_ack and dma_ack SHALL never be high in the same cycle.
REQ-018 rdata registers SHALL hold their value until the next read for that requester.

Reset
REQ-019 While nrst=0, the block SHALL force, immediately and without a clock: state=IDLE, nrd=nwr=ncs=1, bus_doe=0, cpu_ack=dma_ack=0, bus_a=0, bus_dout=0, cpu_rdata=dma_rdata=0.
REQ-020 Reset asserted mid-STRB SHALL release the strobes in the same instant, and no ack SHALL be issued for the aborted transaction.
REQ-021 After nrst rises, the first edge SHALL evaluate requests as in IDLE.

Configuration
REQ-022 With macro CART_DMA_ARB_EN defined, the DMA port SHALL be arbitrated per REQ-005/006.
REQ-023 Without CART_DMA_ARB_EN, dma_req SHALL be ignored, dma_ack SHALL be held at 0, dma_rdata SHALL be held at 0, and only CPU transactions SHALL be issued.

Verification
REQ-024 CPU write 0x2000<-0x05, STRB_CYC=2 -> bus_a=0x2000, nwr low exactly 2 cycles, ncs=1, bus_dout=0x05, cpu_ack 4 cycles after the grant edge.
REQ-025 CPU read 0xA123 with bus_din=0x5A -> ncs=0 ADDR..HOLD, nrd low 2 cycles, cpu_rdata=0x5A with cpu_ack.
REQ-026 cpu_req (read 0x4000) and dma_req (0xC000) raised in the same cycle -> DMA transaction first, dma_ack, one IDLE cycle, then CPU transaction and cpu_ack; acks never overlap.
REQ-027 nrst pulled low during the second STRB cycle of a write -> nwr=1 and bus_doe=0 immediately, no cpu_ack; after release with cpu_req still high -> the full transaction reruns.
REQ-028 Build without CART_DMA_ARB_EN, dma_req=1 continuously -> dma_ack never asserts, and CPU reads complete at normal latency.
